data_sram_responder: RTL and testbench

Responder side of the core's data SRAM interface. It accepts the enable, byte-write-enable, address and write-data signals that the execute stage drives, holds a word-organised memory array, and returns read data after a fixed, parameterised latency with a valid strobe. It sits outside the core, in the SoC or testbench memory wrapper. It also reports out-of-range accesses through a sticky error flag and a captured error address.

---
 rtl/data_sram_responder.sv | 136 +++++++++++++
 tb/tb_data_sram_responder.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder
//
// Responder side of the core's data SRAM interface. It holds a word-organised
// memory array and returns read data after a fixed latency, together with a
// one-cycle valid strobe. Accesses outside the array set a sticky error flag,
// and the byte address of the first such access since reset is captured.
//
// Parameters:
//   DEPTH_LOG2    log2 of the number of 32-bit words in the array
//   READ_LATENCY  cycles from request edge to valid read data (1..4)
//
// Ports:
//   clock               sole clock, rising edge
//   reset               asynchronous, active-low reset
//   data_enabled        request strobe, sampled on the rising edge
//   data_write_enabled  byte-lane write enables; all zero means read
//   data_address        byte address; bits [1:0] ignored for the array
//   data_write_data     lane-aligned store data
//   data_read_data      read data; holds its last value between reads
//   data_read_valid     one-cycle pulse marking data_read_data as fresh
//   address_error       sticky out-of-range flag
//   error_address       byte address of the first out-of-range access
//
// The array itself has no reset; its contents survive reset assertion.

module data_sram_responder #(
    parameter int unsigned DEPTH_LOG2   = 10,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_enabled,
    input  logic [3:0]  data_write_enabled,
    input  logic [31:0] data_address,
    input  logic [31:0] data_write_data,
    output logic [31:0] data_read_data,
    output logic        data_read_valid,
    output logic        address_error,
    output logic [31:0] error_address
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [DEPTH_LOG2-1:0] word_index;
    logic                  in_range;
    logic                  read_req;
    logic                  write_req;

    assign word_index = data_address[DEPTH_LOG2+1:2];
    // Any set bit above the word-index field lands outside the array.
    assign in_range   = ((data_address >> (DEPTH_LOG2 + 2)) == 32'd0);
    assign read_req   = data_enabled && (data_write_enabled == 4'b0000);
    assign write_req  = data_enabled && (data_write_enabled != 4'b0000);

    // ------------------------------------------------------------------
    // Memory array (no reset)
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH];
    logic [31:0] mem_rdata;
    logic [31:0] stage0_data;

    // Array is read as it stands before this edge; a write on the same
    // edge cannot coexist with a read, so no bypass is needed.
    assign mem_rdata   = mem[word_index];
    assign stage0_data = in_range ? mem_rdata : 32'h0000_0000;

    // Writes are suppressed while reset is held so that a clock edge during
    // reset cannot corrupt the preserved contents.
    always_ff @(posedge clock) begin
        if (reset && write_req && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (data_write_enabled[i]) begin
                    mem[word_index][8*i +: 8] <= data_write_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read latency pipeline
    // ------------------------------------------------------------------
    // Each stage data register only loads when its incoming valid is set,
    // so the last stage naturally holds the most recent response and can
    // drive data_read_data directly.
    logic [READ_LATENCY-1:0] valid_q;
    logic [31:0]             data_q [READ_LATENCY];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= 32'h0000_0000;
            end
        end else begin
            valid_q[0] <= read_req;
            if (read_req) begin
                data_q[0] <= stage0_data;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign data_read_valid = valid_q[READ_LATENCY-1];
    assign data_read_data  = data_q[READ_LATENCY-1];

    // ------------------------------------------------------------------
    // Out-of-range reporting
    // ------------------------------------------------------------------
    logic        error_q;
    logic [31:0] error_address_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            error_q         <= 1'b0;
            error_address_q <= 32'h0000_0000;
        end else if (data_enabled && !in_range) begin
            error_q <= 1'b1;
            // Only the first offending address since reset is kept.
            if (!error_q) begin
                error_address_q <= data_address;
            end
        end
    end

    assign address_error = error_q;
    assign error_address = error_address_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Testbench for data_sram_responder. Three instances with READ_LATENCY 1, 2
// and 3 share the same request inputs; each is compared every cycle against
// a behavioural model (word array, history of per-edge responses, sticky
// error state) plus fixed expected values taken from the test plan.

module tb_data_sram_responder;

    localparam int unsigned DL = 10;

    typedef struct packed {
        logic        e;
        logic [3:0]  w;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rd [3];
    logic        rv [3];
    logic        err [3];
    logic [31:0] ea [3];

    always #5 clock = ~clock;

    data_sram_responder #(.DEPTH_LOG2(DL), .READ_LATENCY(1)) u_l1 (
        .clock              (clock),
        .reset              (reset),
        .data_enabled       (en),
        .data_write_enabled (we),
        .data_address       (addr),
        .data_write_data    (wdata),
        .data_read_data     (rd[0]),
        .data_read_valid    (rv[0]),
        .address_error      (err[0]),
        .error_address      (ea[0])
    );

    data_sram_responder #(.DEPTH_LOG2(DL), .READ_LATENCY(2)) u_l2 (
        .clock              (clock),
        .reset              (reset),
        .data_enabled       (en),
        .data_write_enabled (we),
        .data_address       (addr),
        .data_write_data    (wdata),
        .data_read_data     (rd[1]),
        .data_read_valid    (rv[1]),
        .address_error      (err[1]),
        .error_address      (ea[1])
    );

    data_sram_responder #(.DEPTH_LOG2(DL), .READ_LATENCY(3)) u_l3 (
        .clock              (clock),
        .reset              (reset),
        .data_enabled       (en),
        .data_write_enabled (we),
        .data_address       (addr),
        .data_write_data    (wdata),
        .data_read_data     (rd[2]),
        .data_read_valid    (rv[2]),
        .address_error      (err[2]),
        .error_address      (ea[2])
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [31:0] m_mem [1 << DL];
    logic        hv [4];         // hv[0]: response created at the newest edge
    logic [31:0] hd [4];
    logic        exp_valid [3];
    logic [31:0] exp_hold [3];
    logic        exp_err;
    logic [31:0] exp_eaddr;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            hv[i] = 1'b0;
            hd[i] = 32'h0;
        end
        for (int j = 0; j < 3; j++) begin
            exp_valid[j] = 1'b0;
            exp_hold[j]  = 32'h0;
        end
        exp_err   = 1'b0;
        exp_eaddr = 32'h0;
    endtask

    // Drive one request across one rising edge, advance the model, and
    // return 1 time unit after the edge with inputs idle.
    task automatic step(input req_t r);
        logic        ok;
        logic [31:0] rdat;
        int          idx;
        en    = r.e;
        we    = r.w;
        addr  = r.a;
        wdata = r.d;
        @(posedge clock);
        ok   = ((r.a >> (DL + 2)) == 32'd0);
        idx  = int'(r.a[DL+1:2]);
        rdat = ok ? m_mem[idx] : 32'h0;
        if (r.e && r.w != 4'h0 && ok) begin
            for (int b = 0; b < 4; b++) begin
                if (r.w[b]) m_mem[idx][8*b +: 8] = r.d[8*b +: 8];
            end
        end
        if (r.e && !ok) begin
            if (!exp_err) exp_eaddr = r.a;
            exp_err = 1'b1;
        end
        for (int i = 3; i > 0; i--) begin
            hv[i] = hv[i-1];
            hd[i] = hd[i-1];
        end
        hv[0] = r.e && (r.w == 4'h0);
        hd[0] = rdat;
        // Latency L: the response from L-1 edges ago is visible now.
        for (int j = 0; j < 3; j++) begin
            exp_valid[j] = hv[j];
            if (hv[j]) exp_hold[j] = hd[j];
        end
        #1;
        en = 1'b0;
        we = 4'h0;
    endtask

    function automatic req_t mk(input logic e, input logic [3:0] w,
                                input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.e = e;
        r.w = w;
        r.a = a;
        r.d = d;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        en    = 1'b0;
        we    = 4'h0;
        addr  = 32'h0;
        wdata = 32'h0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if ({rv[j], rd[j], err[j], ea[j]} !== 66'h0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got v=%b d=%h e=%b ea=%h, expected all 0",
                         j, rv[j], rd[j], err[j], ea[j]);
            end
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 64; i++) begin
            step(mk(1'b1, 4'hF, 32'(i * 4), $urandom));
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if ({rv[j], rd[j]} !== {exp_valid[j], exp_hold[j]}) begin
                    n_fail++;
                    $display("FAIL fill_resp dut%0d step %0d: got v=%b d=%h, expected v=%b d=%h",
                             j, i, rv[j], rd[j], exp_valid[j], exp_hold[j]);
                end
            end
        end
    endtask

    task automatic test_full_word();
        req_t q[$];
        q.push_back(mk(1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF));
        q.push_back(mk(1'b1, 4'h0, 32'h40, 32'h0));
        for (int k = 0; k < 4; k++) q.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0));
        foreach (q[i]) begin
            step(q[i]);
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if ({rv[j], rd[j]} !== {exp_valid[j], exp_hold[j]}) begin
                    n_fail++;
                    $display("FAIL full_word_resp dut%0d step %0d: got v=%b d=%h, expected v=%b d=%h",
                             j, i, rv[j], rd[j], exp_valid[j], exp_hold[j]);
                end
            end
            if (i == 1 || i == 2) begin
                n_checks++;
                if (rv[0] !== (i == 1) || rd[0] !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL full_word_l1 step %0d: got v=%b d=%h, expected v=%b d=deadbeef",
                             i, rv[0], rd[0], (i == 1));
                end
            end
        end
    endtask

    task automatic test_byte_lanes();
        req_t q[$];
        q.push_back(mk(1'b1, 4'hF,    32'h80, 32'h1122_3344));
        q.push_back(mk(1'b1, 4'b0101, 32'h80, 32'hAABB_CCDD));
        q.push_back(mk(1'b1, 4'h0,    32'h80, 32'h0));
        for (int k = 0; k < 3; k++) q.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0));
        foreach (q[i]) begin
            step(q[i]);
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if ({rv[j], rd[j]} !== {exp_valid[j], exp_hold[j]}) begin
                    n_fail++;
                    $display("FAIL byte_lanes_resp dut%0d step %0d: got v=%b d=%h, expected v=%b d=%h",
                             j, i, rv[j], rd[j], exp_valid[j], exp_hold[j]);
                end
            end
            if (i == 2) begin
                n_checks++;
                if (rv[0] !== 1'b1 || rd[0] !== 32'h11BB_33DD) begin
                    n_fail++;
                    $display("FAIL byte_lanes_l1: got v=%b d=%h, expected v=1 d=11bb33dd",
                             rv[0], rd[0]);
                end
            end
        end
    endtask

    task automatic test_pipeline();
        req_t q[$];
        for (int k = 0; k < 4; k++) q.push_back(mk(1'b1, 4'hF, 32'(k * 4), 32'(k + 1)));
        for (int k = 0; k < 4; k++) q.push_back(mk(1'b1, 4'h0, 32'(k * 4), 32'h0));
        for (int k = 0; k < 5; k++) q.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0));
        foreach (q[i]) begin
            step(q[i]);
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if ({rv[j], rd[j]} !== {exp_valid[j], exp_hold[j]}) begin
                    n_fail++;
                    $display("FAIL pipeline_resp dut%0d step %0d: got v=%b d=%h, expected v=%b d=%h",
                             j, i, rv[j], rd[j], exp_valid[j], exp_hold[j]);
                end
            end
            // Reads at steps 4..7; latency 3 shows them after steps 6..9.
            if (i >= 4) begin
                n_checks++;
                if (rv[2] !== (i >= 6 && i <= 9) ||
                    (i >= 6 && i <= 9 && rd[2] !== 32'(i - 5))) begin
                    n_fail++;
                    $display("FAIL pipeline_l3 step %0d: got v=%b d=%h, expected v=%b d=%0d",
                             i, rv[2], rd[2], (i >= 6 && i <= 9), i - 5);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        req_t q[$];
        q.push_back(mk(1'b1, 4'hF, 32'h1000, 32'h5));
        q.push_back(mk(1'b1, 4'h0, 32'h1000, 32'h0));
        q.push_back(mk(1'b1, 4'h0, 32'h2000, 32'h0));
        q.push_back(mk(1'b1, 4'h0, 32'h0000, 32'h0));
        for (int k = 0; k < 3; k++) q.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0));
        foreach (q[i]) begin
            step(q[i]);
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if ({rv[j], rd[j]} !== {exp_valid[j], exp_hold[j]}) begin
                    n_fail++;
                    $display("FAIL oor_resp dut%0d step %0d: got v=%b d=%h, expected v=%b d=%h",
                             j, i, rv[j], rd[j], exp_valid[j], exp_hold[j]);
                end
                n_checks++;
                if ({err[j], ea[j]} !== {1'b1, 32'h0000_1000}) begin
                    n_fail++;
                    $display("FAIL oor_error dut%0d step %0d: got e=%b ea=%h, expected e=1 ea=00001000",
                             j, i, err[j], ea[j]);
                end
            end
            if (i == 1 || i == 2 || i == 3) begin
                n_checks++;
                if (rv[0] !== 1'b1 || rd[0] !== ((i == 3) ? 32'h1 : 32'h0)) begin
                    n_fail++;
                    $display("FAIL oor_l1 step %0d: got v=%b d=%h, expected v=1 d=%h",
                             i, rv[0], rd[0], (i == 3) ? 32'h1 : 32'h0);
                end
            end
        end
    endtask

    task automatic test_midflight_reset();
        req_t q[$];
        step(mk(1'b1, 4'h0, 32'h4, 32'h0));
        #2;
        reset = 1'b0;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            #1;
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if ({rv[j], rd[j], err[j], ea[j]} !== 66'h0) begin
                    n_fail++;
                    $display("FAIL midreset_outputs dut%0d sample %0d: got v=%b d=%h e=%b ea=%h, expected all 0",
                             j, c, rv[j], rd[j], err[j], ea[j]);
                end
            end
            @(posedge clock);
        end
        #4;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) q.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0));
        q.push_back(mk(1'b1, 4'h0, 32'h4, 32'h0));
        q.push_back(mk(1'b1, 4'h0, 32'h8, 32'h0));
        for (int k = 0; k < 3; k++) q.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0));
        foreach (q[i]) begin
            step(q[i]);
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if ({rv[j], rd[j], err[j], ea[j]} !==
                    {exp_valid[j], exp_hold[j], exp_err, exp_eaddr}) begin
                    n_fail++;
                    $display("FAIL midreset_after dut%0d step %0d: got v=%b d=%h e=%b, expected v=%b d=%h e=%b",
                             j, i, rv[j], rd[j], err[j], exp_valid[j], exp_hold[j], exp_err);
                end
            end
            // Latency 2: reads at steps 3,4 appear after steps 4,5.
            if (i >= 4 && i <= 5) begin
                n_checks++;
                if (rv[1] !== 1'b1 || rd[1] !== 32'(i - 2)) begin
                    n_fail++;
                    $display("FAIL midreset_l2 step %0d: got v=%b d=%h, expected v=1 d=%0d",
                             i, rv[1], rd[1], i - 2);
                end
            end
        end
    endtask

    task automatic test_random();
        req_t r;
        for (int i = 0; i < 300; i++) begin
            r.e = ($urandom % 4) != 0;
            r.w = (($urandom % 2) == 0) ? 4'h0 : 4'($urandom);
            r.d = $urandom;
            if (($urandom % 16) == 0) r.a = $urandom | 32'h0000_1000;
            else                       r.a = 32'($urandom % 256);
            step(r);
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if ({rv[j], rd[j], err[j], ea[j]} !==
                    {exp_valid[j], exp_hold[j], exp_err, exp_eaddr}) begin
                    n_fail++;
                    $display("FAIL random dut%0d step %0d: got v=%b d=%h e=%b ea=%h, expected v=%b d=%h e=%b ea=%h",
                             j, i, rv[j], rd[j], err[j], ea[j],
                             exp_valid[j], exp_hold[j], exp_err, exp_eaddr);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(mk(1'b0, 4'h0, 32'h0, 32'h0));
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if ({rv[j], rd[j]} !== {exp_valid[j], exp_hold[j]}) begin
                    n_fail++;
                    $display("FAIL random_flush dut%0d step %0d: got v=%b d=%h, expected v=%b d=%h",
                             j, i, rv[j], rd[j], exp_valid[j], exp_hold[j]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_word();
        test_byte_lanes();
        test_pipeline();
        test_out_of_range();
        test_midflight_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
